ctrl_sequencer: RTL and testbench
=================================

// Module: ctrl_sequencer
// PURPOSE
// Multicycle control sequencer for the accumulator CPU: holds the state register,
// next-state logic and control decode in one block. Fetches a variable-length
// instruction (1..IR_BYTES bytes) with a memory ready handshake. Dispatches on
// opcode class and addressing mode. Owns the stack pointer, with overflow/underflow.
// Sits between IR/flags and the datapath mux/load controls.
// PARAMETERS
// IR_BYTES     3      max instruction length in bytes (1 opcode + operand bytes)
// SP_W         8      stack pointer width
// STACK_TOP    8'hFF  SP value after reset; stack grows downward
// STACK_DEPTH  16     max entries; must be <= 2**SP_W
// PORTS
// clk          in   1            system clock, rising edge
// reset        in   1            asynchronous, active-high
// opcode       in   8            IR byte 0: [7:5] class, [4:3] mode, [1:0] len (extra bytes)
// zero         in   1            ALU zero flag
// mem_ready    in   1            memory completes the current mem_req this cycle
// mem_req      out  1            memory access request, held until mem_ready
// memwrite     out  1            write qualifier for mem_req (1 = write)
// adrsrc       out  2            address mux: 00 PC, 01 memdir, 10 PC-rel, 11 SP
// irwrite      out  IR_BYTES     one-hot IR byte load strobe
// pc_inc       out  1            PC += 1
// pcwrite      out  1            PC <= jump target
// ldAB, ldBB   out  1 each       accumulator A / B load
// regwrite     out  1            register file write
// shiftsrc     out  3            0 none, 1 ASR, 2 LSR, 3 ASL, 4 LSL
// sp_out       out  SP_W         current stack pointer
// stk_ovf      out  1            sticky: push attempted on full stack
// stk_unf      out  1            sticky: pop attempted on empty stack
// halted       out  1            high in HALT or FAULT
// state_o      out  4            current state encoding (debug)
// BEHAVIOUR
// - States: RST_SP=0, FETCH=1, DECODE=2, OPRD=3, EXEC=4, WB=5, JMP=6, STK=7, HALT=8, FAULT=9.
// - Control outputs decode combinationally from the registered state, byte count cnt and mem_ready.
// - Any output not listed as active in a state is 0.
// - Reset (async): state=RST_SP, cnt=0, sp=STACK_TOP, occupancy=0, stk_ovf=stk_unf=0.
// - During reset every output is 0, except sp_out=STACK_TOP and state_o=0.
// - If reset asserts mid-access, mem_req drops in the same cycle.
// - RST_SP: one cycle, then FETCH.
// - FETCH: mem_req=1, adrsrc=00, irwrite=0 until mem_ready.
//   - On mem_ready: irwrite[cnt]=1 and pc_inc=1 for that cycle, cnt++, go to DECODE.
//   - mem_ready while mem_req=0 is ignored.
// - DECODE: if len >= IR_BYTES, go to FAULT.
//   - Else if cnt <= len, go to FETCH for the next byte.
//   - Else reset cnt to 0 and dispatch on class:
//     0 ALU->OPRD; 1 SHIFT->EXEC; 2 JMP, 3 JZ, 4 JNZ->JMP; 5 PUSH, 6 POP->STK; 7->HALT.
//   - PUSH dispatch with occupancy==STACK_DEPTH goes to FAULT and sets stk_ovf.
//   - POP dispatch with occupancy==0 goes to FAULT and sets stk_unf.
// - OPRD, by mode:
//   - 0 immediate / 1 register: ldBB=1 for one cycle, go to EXEC.
//   - 2 memdir / 3 PC-rel: mem_req=1 with adrsrc=01 / 10 until mem_ready; ldBB=1 on mem_ready, go to EXEC.
// - EXEC: ALU class gives ldAB=1; SHIFT class gives shiftsrc=mode+1 and ldAB=1. Then WB.
// - WB: regwrite=1 for one cycle, then FETCH.
// - JMP: one cycle, then FETCH.
//   - pcwrite = 1 for JMP, zero for JZ, ~zero for JNZ.
//   - zero is sampled in this cycle.
// - STK PUSH: mem_req=1, memwrite=1, adrsrc=11 at sp until mem_ready.
//   - Then sp--, occupancy++, go to FETCH.
// - STK POP: on the first STK cycle sp++ and occupancy--; the read uses the updated sp.
//   - mem_req=1, adrsrc=11 until mem_ready, then ldBB=1 and go to FETCH.
// - HALT and FAULT are terminal until reset; halted=1.
// - sp arithmetic is modulo 2**SP_W; the occupancy check guarantees no wrap within STACK_DEPTH.
// TESTING
// - Reset, opcode 8'hE0 (HALT, len 0), mem_ready=1:
//   -> states 0,1,2,8; one pc_inc; irwrite=001; halted=1.
// - ALU memdir 3-byte (8'h12), mem_ready 2 cycles late each access:
//   -> irwrite 001,010,100; 3 pc_inc; mem_req held through the waits; ldBB, ldAB, regwrite one pulse each.
// - JZ with zero=1 -> pcwrite pulse.
//   - JZ with zero=0 -> no pcwrite.
//   - JNZ with zero=0 -> pcwrite pulse.
// - STACK_DEPTH=4, five PUSHes:
//   -> sp FF,FE,FD,FC,FB; fifth push enters FAULT with stk_ovf=1 and no memwrite.
// - POP after reset -> FAULT, stk_unf=1, sp stays FF.
//   - With one entry pushed, POP -> sp=FF, read at FF, ldBB on mem_ready.
// - Opcode len=3 with IR_BYTES=3 -> FAULT after byte 0.
//   - Reset during FETCH with mem_req=1 -> mem_req=0 in the same cycle.

Source files
------------

// File: rtl/ctrl_sequencer.sv
// rtl/ctrl_sequencer.sv - multicycle fetch/decode/execute sequencer with stack pointer
module ctrl_sequencer #(
    parameter int              IR_BYTES    = 3,
    parameter int              SP_W        = 8,
    parameter logic [SP_W-1:0] STACK_TOP   = 8'hFF,
    parameter int              STACK_DEPTH = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          opcode,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                memwrite,
    output logic [1:0]          adrsrc,
    output logic [IR_BYTES-1:0] irwrite,
    output logic                pc_inc,
    output logic                pcwrite,
    output logic                ldAB,
    output logic                ldBB,
    output logic                regwrite,
    output logic [2:0]          shiftsrc,
    output logic [SP_W-1:0]     sp_out,
    output logic                stk_ovf,
    output logic                stk_unf,
    output logic                halted,
    output logic [3:0]          state_o
);

    localparam int CNT_W = $clog2(IR_BYTES + 1);
    localparam int OCC_W = $clog2(STACK_DEPTH + 1);

    typedef enum logic [3:0] {
        S_RST_SP = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_OPRD = 4'd3, S_EXEC = 4'd4,
        S_WB = 4'd5, S_JMP = 4'd6, S_STK = 4'd7, S_HALT = 4'd8, S_FAULT = 4'd9
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SP_W-1:0]  sp_q, sp_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             ovf_q, ovf_d, unf_q, unf_d;

    logic [2:0] op_class;
    logic [1:0] op_mode, op_len;
    logic       op_unused;
    assign op_class  = opcode[7:5];
    assign op_mode   = opcode[4:3];
    assign op_len    = opcode[1:0];
    assign op_unused = opcode[2];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_RST_SP;
            cnt_q   <= '0;
            sp_q    <= STACK_TOP;
            occ_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sp_q    <= sp_d;
            occ_q   <= occ_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sp_d     = sp_q;
        occ_d    = occ_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        mem_req  = 1'b0;
        memwrite = 1'b0;
        adrsrc   = 2'b00;
        irwrite  = '0;
        pc_inc   = 1'b0;
        pcwrite  = 1'b0;
        ldAB     = 1'b0;
        ldBB     = 1'b0;
        regwrite = 1'b0;
        shiftsrc = 3'd0;
        halted   = 1'b0;
        case (state_q)
            S_RST_SP: state_d = S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    irwrite = IR_BYTES'(1) << cnt_q;
                    pc_inc  = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (int'(op_len) >= IR_BYTES) begin
                    state_d = S_FAULT;
                end else if (int'(cnt_q) <= int'(op_len)) begin
                    state_d = S_FETCH;
                end else begin
                    cnt_d = '0;
                    case (op_class)
                        3'd0:                state_d = S_OPRD;
                        3'd1:                state_d = S_EXEC;
                        3'd2, 3'd3, 3'd4:    state_d = S_JMP;
                        3'd5: begin
                            if (occ_q == OCC_W'(STACK_DEPTH)) begin
                                state_d = S_FAULT;
                                ovf_d   = 1'b1;
                            end else begin
                                state_d = S_STK;
                            end
                        end
                        3'd6: begin
                            if (occ_q == '0) begin
                                state_d = S_FAULT;
                                unf_d   = 1'b1;
                            end else begin
                                state_d = S_STK;
                            end
                        end
                        default:             state_d = S_HALT;
                    endcase
                end
            end
            S_OPRD: begin
                if (!op_mode[1]) begin
                    ldBB    = 1'b1;
                    state_d = S_EXEC;
                end else begin
                    mem_req = 1'b1;
                    adrsrc  = op_mode[0] ? 2'b10 : 2'b01;
                    if (mem_ready) begin
                        ldBB    = 1'b1;
                        state_d = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                ldAB = 1'b1;
                if (op_class == 3'd1) shiftsrc = {1'b0, op_mode} + 3'd1;
                state_d = S_WB;
            end
            S_WB: begin
                regwrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_JMP: begin
                case (op_class)
                    3'd2:    pcwrite = 1'b1;
                    3'd3:    pcwrite = zero;
                    3'd4:    pcwrite = ~zero;
                    default: pcwrite = 1'b0;
                endcase
                state_d = S_FETCH;
            end
            S_STK: begin
                if (op_class == 3'd5) begin
                    mem_req  = 1'b1;
                    memwrite = 1'b1;
                    adrsrc   = 2'b11;
                    if (mem_ready) begin
                        sp_d    = sp_q - SP_W'(1);
                        occ_d   = occ_q + OCC_W'(1);
                        state_d = S_FETCH;
                    end
                // POP: cnt doubles as the "sp already bumped" flag so the read sees the new sp
                end else if (cnt_q == '0) begin
                    sp_d  = sp_q + SP_W'(1);
                    occ_d = occ_q - OCC_W'(1);
                    cnt_d = CNT_W'(1);
                end else begin
                    mem_req = 1'b1;
                    adrsrc  = 2'b11;
                    if (mem_ready) begin
                        ldBB    = 1'b1;
                        cnt_d   = '0;
                        state_d = S_FETCH;
                    end
                end
            end
            S_HALT, S_FAULT: halted = 1'b1;
            default: state_d = S_FAULT;
        endcase
    end

    assign sp_out  = sp_q;
    assign stk_ovf = ovf_q;
    assign stk_unf = unf_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb/tb_ctrl_sequencer.sv - randomized per-instruction cycle-script checking of ctrl_sequencer
module tb_ctrl_sequencer;

    localparam int IRB   = 3;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] opcode = 8'h00;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, memwrite, pc_inc, pcwrite, ldAB, ldBB, regwrite;
    logic [1:0] adrsrc;
    logic [2:0] irwrite, shiftsrc;
    logic [7:0] sp_out;
    logic       stk_ovf, stk_unf, halted;
    logic [3:0] state_o;

    always #5 clk = ~clk;

    ctrl_sequencer #(.IR_BYTES(IRB), .SP_W(8), .STACK_TOP(8'hFF), .STACK_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .memwrite(memwrite), .adrsrc(adrsrc), .irwrite(irwrite),
        .pc_inc(pc_inc), .pcwrite(pcwrite), .ldAB(ldAB), .ldBB(ldBB), .regwrite(regwrite),
        .shiftsrc(shiftsrc), .sp_out(sp_out), .stk_ovf(stk_ovf), .stk_unf(stk_unf),
        .halted(halted), .state_o(state_o)
    );

    // One expected cycle: inputs to drive plus every output the DUT must show
    typedef struct {
        logic rst; logic [7:0] op; logic rdy; logic z;
        logic [3:0] st; logic req, wr; logic [1:0] adr; logic [2:0] irw;
        logic pcinc, pcw, lda, ldb, rw; logic [2:0] sh; logic [7:0] sp;
        logic ovf, unf, hlt;
    } cyc_t;

    cyc_t q[$];
    cyc_t cur;
    bit   cur_valid = 0;

    int checks = 0, failures = 0;
    logic [7:0] sp_m;
    int  occ_m;
    logic ovf_m, unf_m;

    int n_pcinc, n_pcw, n_lda, n_ldb, n_rw, n_req, n_wr, last_st;
    logic [8:0]  irw_hist;
    logic [63:0] st_hist;
    logic [7:0]  rd_sp;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic cyc_t blank(input logic [7:0] op);
        cyc_t c;
        c.rst = 1'b0; c.op = op; c.rdy = 1'($urandom); c.z = 1'($urandom);
        c.st = 4'd0; c.req = 0; c.wr = 0; c.adr = 2'b00; c.irw = 3'b000;
        c.pcinc = 0; c.pcw = 0; c.lda = 0; c.ldb = 0; c.rw = 0; c.sh = 3'd0;
        c.sp = sp_m; c.ovf = ovf_m; c.unf = unf_m; c.hlt = 0;
        return c;
    endfunction

    task automatic access(input cyc_t c, input int w, output cyc_t done);
        int n;
        n = (w < 0) ? int'($urandom_range(0, 3)) : w;
        c.rdy = 1'b0;
        for (int i = 0; i < n; i++) q.push_back(c);
        done = c;
        done.rdy = 1'b1;
    endtask

    task automatic add_term(input logic [7:0] op, input logic [3:0] st);
        cyc_t c;
        for (int i = 0; i < 3; i++) begin
            c = blank(op); c.st = st; c.hlt = 1'b1; q.push_back(c);
        end
    endtask

    task automatic gen_reset();
        cyc_t c;
        sp_m = 8'hFF; occ_m = 0; ovf_m = 1'b0; unf_m = 1'b0;
        for (int i = 0; i < 2; i++) begin
            c = blank(8'h00); c.rst = 1'b1; q.push_back(c);
        end
        c = blank(8'h00); q.push_back(c);
    endtask

    // Builds the cycle-by-cycle script of one instruction from its opcode fields
    task automatic gen_instr(input logic [7:0] op, input logic z, input int w, output bit term);
        cyc_t c;
        int cls, mode, len;
        cls = int'(op[7:5]); mode = int'(op[4:3]); len = int'(op[1:0]);
        term = 0;
        for (int k = 0; k <= len; k++) begin
            c = blank(op); c.st = 4'd1; c.req = 1'b1;
            access(c, w, c);
            c.irw = 3'(1 << k); c.pcinc = 1'b1; q.push_back(c);
            c = blank(op); c.st = 4'd2; q.push_back(c);
            if (len >= IRB) begin
                add_term(op, 4'd9); term = 1; return;
            end
        end
        case (cls)
            0: begin
                c = blank(op); c.st = 4'd3;
                if (mode < 2) begin
                    c.ldb = 1'b1; q.push_back(c);
                end else begin
                    c.req = 1'b1; c.adr = (mode == 2) ? 2'b01 : 2'b10;
                    access(c, w, c); c.ldb = 1'b1; q.push_back(c);
                end
                c = blank(op); c.st = 4'd4; c.lda = 1'b1; q.push_back(c);
                c = blank(op); c.st = 4'd5; c.rw = 1'b1; q.push_back(c);
            end
            1: begin
                c = blank(op); c.st = 4'd4; c.lda = 1'b1; c.sh = 3'(mode + 1); q.push_back(c);
                c = blank(op); c.st = 4'd5; c.rw = 1'b1; q.push_back(c);
            end
            2, 3, 4: begin
                c = blank(op); c.st = 4'd6; c.z = z;
                c.pcw = (cls == 2) || (cls == 3 && z) || (cls == 4 && !z);
                q.push_back(c);
            end
            5: begin
                if (occ_m == DEPTH) begin
                    ovf_m = 1'b1; add_term(op, 4'd9); term = 1;
                end else begin
                    c = blank(op); c.st = 4'd7; c.req = 1'b1; c.wr = 1'b1; c.adr = 2'b11;
                    access(c, w, c); q.push_back(c);
                    sp_m = sp_m - 8'd1; occ_m++;
                end
            end
            6: begin
                if (occ_m == 0) begin
                    unf_m = 1'b1; add_term(op, 4'd9); term = 1;
                end else begin
                    c = blank(op); c.st = 4'd7; q.push_back(c);
                    sp_m = sp_m + 8'd1; occ_m--;
                    c = blank(op); c.st = 4'd7; c.req = 1'b1; c.adr = 2'b11;
                    access(c, w, c); c.ldb = 1'b1; q.push_back(c);
                end
            end
            default: begin
                add_term(op, 4'd8); term = 1;
            end
        endcase
    endtask

    task automatic run_q();
        while (q.size() > 0) begin
            @(negedge clk);
            cur = q.pop_front();
            reset = cur.rst; opcode = cur.op; mem_ready = cur.rdy; zero = cur.z;
            cur_valid = 1;
        end
        #2;
    endtask

    task automatic clr_obs();
        n_pcinc = 0; n_pcw = 0; n_lda = 0; n_ldb = 0; n_rw = 0; n_req = 0; n_wr = 0;
        irw_hist = '0; st_hist = '0; last_st = -1; rd_sp = 8'h00;
    endtask

    always begin
        @(negedge clk);
        #1;
        if (cur_valid) begin
            chk("state", 64'(state_o), 64'(cur.st));
            chk("mem_req", 64'(mem_req), 64'(cur.req));
            chk("memwrite", 64'(memwrite), 64'(cur.wr));
            chk("adrsrc", 64'(adrsrc), 64'(cur.adr));
            chk("irwrite", 64'(irwrite), 64'(cur.irw));
            chk("pc_inc", 64'(pc_inc), 64'(cur.pcinc));
            chk("pcwrite", 64'(pcwrite), 64'(cur.pcw));
            chk("ldAB", 64'(ldAB), 64'(cur.lda));
            chk("ldBB", 64'(ldBB), 64'(cur.ldb));
            chk("regwrite", 64'(regwrite), 64'(cur.rw));
            chk("shiftsrc", 64'(shiftsrc), 64'(cur.sh));
            chk("sp_out", 64'(sp_out), 64'(cur.sp));
            chk("stk_ovf", 64'(stk_ovf), 64'(cur.ovf));
            chk("stk_unf", 64'(stk_unf), 64'(cur.unf));
            chk("halted", 64'(halted), 64'(cur.hlt));
            n_pcinc += int'(pc_inc); n_pcw += int'(pcwrite); n_lda += int'(ldAB);
            n_ldb += int'(ldBB); n_rw += int'(regwrite); n_req += int'(mem_req);
            n_wr += int'(memwrite);
            if (irwrite != 3'b000) irw_hist = {irw_hist[5:0], irwrite};
            if (int'(state_o) != last_st) begin
                st_hist = {st_hist[59:0], state_o};
                last_st = int'(state_o);
            end
            if (mem_req && adrsrc == 2'b11 && !memwrite) rd_sp = sp_out;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit term;
        logic [7:0] op;

        // HALT, single byte, memory always ready
        gen_reset(); gen_instr(8'hE0, 1'b0, 0, term); clr_obs(); run_q();
        chk("halt_states", st_hist, 64'h0128);
        chk("halt_pc_inc", 64'(n_pcinc), 64'd1);
        chk("halt_irwrite", 64'(irw_hist), 64'b000_000_001);
        chk("halt_halted", 64'(halted), 64'd1);

        // ALU memdir, three bytes, two wait cycles on every access
        gen_reset(); gen_instr(8'h12, 1'b0, 2, term); clr_obs(); run_q();
        chk("alu_states", st_hist, 64'h0121212345);
        chk("alu_pc_inc", 64'(n_pcinc), 64'd3);
        chk("alu_irwrite", 64'(irw_hist), 64'b001_010_100);
        chk("alu_req_cycles", 64'(n_req), 64'd12);
        chk("alu_pulses", {32'(n_ldb), 16'(n_lda), 16'(n_rw)}, {32'd1, 16'd1, 16'd1});

        // Conditional jumps
        gen_instr(8'h60, 1'b1, -1, term); clr_obs(); run_q();
        chk("jz_taken", 64'(n_pcw), 64'd1);
        gen_instr(8'h60, 1'b0, -1, term); clr_obs(); run_q();
        chk("jz_not_taken", 64'(n_pcw), 64'd0);
        gen_instr(8'h80, 1'b0, -1, term); clr_obs(); run_q();
        chk("jnz_taken", 64'(n_pcw), 64'd1);

        // Fill the stack then overflow it
        gen_reset();
        for (int i = 0; i < DEPTH; i++) gen_instr(8'hA0, 1'b0, -1, term);
        run_q();
        gen_instr(8'hA0, 1'b0, -1, term); clr_obs(); run_q();
        chk("ovf_state", 64'(state_o), 64'd9);
        chk("ovf_flag", 64'(stk_ovf), 64'd1);
        chk("ovf_sp", 64'(sp_out), 64'hFB);
        chk("ovf_no_write", 64'(n_wr), 64'd0);

        // Pop on empty stack
        gen_reset(); gen_instr(8'hC0, 1'b0, -1, term); clr_obs(); run_q();
        chk("unf_state", 64'(state_o), 64'd9);
        chk("unf_flag", 64'(stk_unf), 64'd1);
        chk("unf_sp", 64'(sp_out), 64'hFF);

        // Push then pop
        gen_reset(); gen_instr(8'hA0, 1'b0, -1, term); gen_instr(8'hC0, 1'b0, 1, term);
        clr_obs(); run_q();
        chk("pop_sp", 64'(sp_out), 64'hFF);
        chk("pop_read_addr", 64'(rd_sp), 64'hFF);
        chk("pop_ldbb", 64'(n_ldb), 64'd1);

        // Length field beyond IR_BYTES
        gen_reset(); gen_instr(8'h03, 1'b0, -1, term); clr_obs(); run_q();
        chk("len_fault_state", 64'(state_o), 64'd9);
        chk("len_fault_pc_inc", 64'(n_pcinc), 64'd1);

        // Reset asserted mid-fetch drops mem_req without a clock edge
        gen_reset(); run_q();
        @(negedge clk);
        cur_valid = 0; mem_ready = 1'b0;
        #1;
        chk("midfetch_req_before", 64'(mem_req), 64'd1);
        #1 reset = 1'b1;
        #1;
        chk("midfetch_req_after", 64'(mem_req), 64'd0);
        chk("midfetch_state_after", 64'(state_o), 64'd0);

        // Random instruction stream
        gen_reset(); run_q();
        for (int i = 0; i < 300; i++) begin
            op = 8'($urandom);
            if (op[1:0] == 2'd3 && $urandom_range(0, 7) != 0) op[1:0] = 2'($urandom_range(0, 2));
            if (op[7:5] == 3'd7 && $urandom_range(0, 3) != 0) op[7:5] = 3'($urandom_range(0, 6));
            gen_instr(op, 1'($urandom), -1, term);
            if (term) gen_reset();
            run_q();
        end

        cur_valid = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
